// File: rtl/nand_sync_fifo.sv
// Single-clock page data buffer between the NAND I/O datapath and the host DMA side.
// Standard (registered) or first-word-fall-through read, watermarks, flush and sticky errors.
module nand_sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = 2**ADDR_W - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned    Depth     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt  = Depth[ADDR_W:0];
  localparam logic [ADDR_W:0] AFullCnt  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEmptyCnt = AEMPTY_TH[ADDR_W:0];

  logic [WIDTH-1:0] mem [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Flush swallows any request in the same cycle, so gate acceptance here.
  always_comb begin
    wr_acc   = wr_en & ~full_q & ~flush;
    rd_acc   = rd_en & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
      ovf_d   = ovf_q | (wr_en & full_q);
      udf_d   = udf_q | (rd_en & empty_q);
    end
    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFullCnt);
    aempty_d = (count_d <= AEmptyCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout       = mem[rd_ptr_q];
    assign dout_valid = ~empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
